// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared Q1.15 / BCD constants, FSM states and digit validity check
package fixed_point_pkg;
    localparam int FRAC_BITS = 15;
    localparam int SCALE = 1000;
    localparam int DIV_W = 25;
    localparam int ROUND_ADD = SCALE - 1;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    typedef enum logic [2:0] {IDLE, CHECK, ACCUM, DIVIDE, DONE} state_t;
    function automatic logic bcd_valid(input logic [15:0] bcd);
        return bcd[15:12] == 4'd0 && bcd[11:8] <= BCD_MAX_DIGIT &&
               bcd[7:4] <= BCD_MAX_DIGIT && bcd[3:0] <= BCD_MAX_DIGIT;
    endfunction
endpackage

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: one quotient bit per cycle, MSB first; done marks the final iteration with quotient valid
module seq_restoring_divider
    import fixed_point_pkg::*;
#(
    parameter int W = DIV_W,
    parameter int QW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [10:0]   divisor,
    output logic [QW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(W);
    logic          run;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dq;
    logic [W-1:0]  q_full;
    logic [9:0]    rem;
    logic [10:0]   rem_sh;
    logic          ge;
    // quotient bits shift into the dividend register as its bits are consumed
    always_comb begin
        rem_sh = {rem, dq[W-1]};
        ge = rem_sh >= divisor;
        q_full = {dq[W-2:0], ge};
        quotient = q_full[QW-1:0];
        done = run && cnt == CW'(W - 1);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            run <= 1'b0;
            cnt <= '0;
            dq <= '0;
            rem <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            dq <= dividend;
            rem <= '0;
        end else if (run) begin
            run <= !done;
            cnt <= cnt + 1'b1;
            dq <= q_full;
            rem <= 10'(ge ? rem_sh - divisor : rem_sh);
        end
    end
endmodule

// File: rtl/decimal_to_fixed_point.sv
// decimal_to_fixed_point: 0.DDD BCD thousandths to Q1.15, rounded up so the forward conversion returns the same digits
module decimal_to_fixed_point
    import fixed_point_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bcdInput,
    output logic [15:0] fixedPointOutput,
    output logic        busy,
    output logic        done,
    output logic        error
);
    state_t            state, state_n;
    logic [15:0]       bcd_q;
    logic [9:0]        acc, acc_n;
    logic [1:0]        dcnt;
    logic [3:0]        digit;
    logic              valid, div_start, div_done;
    logic [DIV_W-1:0]  dividend;
    logic [15:0]       quotient;
    // invalid digits are rejected on the first accumulate step, two edges after start
    always_comb begin
        valid = bcd_valid(bcd_q);
        digit = bcd_q[{~dcnt, 2'b00} +: 4];
        acc_n = acc * 10'd10 + {6'd0, digit};
        dividend = (DIV_W'(acc_n) << FRAC_BITS) + DIV_W'(ROUND_ADD);
        div_start = state == ACCUM && valid && dcnt == 2'd3;
        busy = state inside {CHECK, ACCUM, DIVIDE};
        done = state == DONE;
        state_n = state;
        case (state)
            IDLE:    state_n = start ? CHECK : IDLE;
            CHECK:   state_n = ACCUM;
            ACCUM:   state_n = !valid ? DONE : div_start ? DIVIDE : ACCUM;
            DIVIDE:  state_n = div_done ? DONE : DIVIDE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            bcd_q <= '0;
            acc <= '0;
            dcnt <= '0;
            fixedPointOutput <= '0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) bcd_q <= bcdInput;
            if (state == CHECK) begin
                acc <= '0;
                dcnt <= '0;
            end
            if (state == ACCUM) begin
                acc <= acc_n;
                dcnt <= dcnt + 1'b1;
            end
            if (state == ACCUM && !valid) begin
                fixedPointOutput <= '0;
                error <= 1'b1;
            end
            if (state == DIVIDE && div_done) begin
                fixedPointOutput <= quotient;
                error <= 1'b0;
            end
        end
    end
    seq_restoring_divider #(.W(DIV_W), .QW(16)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (11'(SCALE)),
        .quotient (quotient),
        .done     (div_done)
    );
endmodule

// File: tb/tb_decimal_to_fixed_point.sv
// tb_decimal_to_fixed_point: vector table, exhaustive round-trip, random model checks and handshake/reset corner cases
module tb_decimal_to_fixed_point;
    logic        clock = 1'b0;
    logic        reset, start;
    logic [15:0] bcdInput;
    logic [15:0] fixedPointOutput;
    logic        busy, done, error;
    int errors = 0;
    int checks = 0;

    decimal_to_fixed_point dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .bcdInput         (bcdInput),
        .fixedPointOutput (fixedPointOutput),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] out;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ceil_q15(input int n);
        return (n * 32768 + 999) / 1000;
    endfunction

    function automatic int forward(input int x);
        return (x * 1000) >> 15;
    endfunction

    // decodes the digits arithmetically and applies the conversion rule
    task automatic model(input logic [15:0] b, output int out, output int err, output int lat);
        int d3, d2, d1, d0;
        d3 = int'(b[15:12]);
        d2 = int'(b[11:8]);
        d1 = int'(b[7:4]);
        d0 = int'(b[3:0]);
        err = (d3 != 0 || d2 > 9 || d1 > 9 || d0 > 9) ? 1 : 0;
        out = err ? 0 : ceil_q15(d2 * 100 + d1 * 10 + d0);
        lat = err ? 2 : 30;
    endtask

    task automatic run_conv(input logic [15:0] b, output logic [15:0] res, output logic er, output int lat);
        @(negedge clock);
        bcdInput = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        res = fixedPointOutput;
        er = error;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res, b;
        logic        er;
        int          lat, eo, ee, el, last_out, dones, n, x;
        logic [31:0] r;
        vecs[0] = '{16'h0500, 16'h4000, 1'b0, 30};
        vecs[1] = '{16'h0999, 16'h7FE0, 1'b0, 30};
        vecs[2] = '{16'h0001, 16'h0021, 1'b0, 30};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 30};
        vecs[4] = '{16'h0A12, 16'h0000, 1'b1, 2};
        vecs[5] = '{16'h1000, 16'h0000, 1'b1, 2};
        vecs[6] = '{16'h0250, 16'h2000, 1'b0, 30};
        reset = 1'b1;
        start = 1'b0;
        bcdInput = 16'h0;
        repeat (3) @(negedge clock);
        chk("reset_out", int'(fixedPointOutput), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_error", int'(error), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].bcd, res, er, lat);
            chk($sformatf("vec%0d_out", i), int'(res), int'(vecs[i].out));
            chk($sformatf("vec%0d_err", i), int'(er), int'(vecs[i].err));
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        for (int i = 0; i < 1000; i++) begin
            b = 16'(((i / 100) << 8) | (((i / 10) % 10) << 4) | (i % 10));
            run_conv(b, res, er, lat);
            x = int'(res);
            chk($sformatf("roundtrip_%0d", i), forward(x), i);
            if (i > 0) chk($sformatf("below_%0d", i), forward(x - 1), i - 1);
        end

        last_out = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            b = r[15:0];
            if (r[20]) b = 16'({4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
            model(b, eo, ee, el);
            run_conv(b, res, er, lat);
            chk($sformatf("rand_out_%h", b), int'(res), eo);
            chk($sformatf("rand_err_%h", b), int'(er), ee);
            chk($sformatf("rand_lat_%h", b), lat, el);
            last_out = eo;
        end

        // start held high throughout, input scrambled after latching
        model(16'h0123, eo, ee, el);
        @(negedge clock);
        bcdInput = 16'h0123;
        start = 1'b1;
        @(negedge clock);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
            bcdInput = 16'($urandom);
            if (lat == 10) chk("hold_prev_out", int'(fixedPointOutput), last_out);
        end
        start = 1'b0;
        chk("held_lat", lat, el);
        chk("held_out", int'(fixedPointOutput), eo);
        chk("held_err", int'(error), ee);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("held_extra_done", dones, 0);

        // abort during the tenth divide cycle
        @(negedge clock);
        bcdInput = 16'h0777;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        chk("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_out", int'(fixedPointOutput), 0);
        chk("abort_error", int'(error), 0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
